spike_event_arbiter: RTL
========================

Name: spike_event_arbiter

Overview:
- Round-robin arbiter that serialises single-cycle spike pulses from N neurons of one layer into a stream of neuron addresses.
- Sits between the neuron array and the address-event (AER) output/router port.
- Holds at most one event per neuron until it is granted.
- Drives a one-hot acknowledge back to the granted neuron.

Parameters:
- N, 8, number of neuron request lines; N >= 2.
- M, $clog2(N), localparam; address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- spike_req  input  N  per-neuron spike pulse; bit i high for one cycle means neuron i fired.
- flush  input  1  synchronous clear of all pending events, e.g. at a timestep boundary.
- out_valid  output  1  out_addr holds a valid event.
- out_ready  input  1  downstream accepts the event when out_valid && out_ready.
- out_addr  output  M  index of the granted neuron.
- grant_ack  output  N  one-hot, one-cycle pulse on the neuron just loaded into the output register.
- busy  output  1  high when any pending bit or out_valid is set.

Behaviour:
- Reset (async, rst_n low):
  - pending = 0, rr_ptr = 0.
  - out_valid = 0, out_addr = 0, grant_ack = 0.
  - Takes effect immediately, mid-transfer included. In-flight and pending events are discarded.
- Pending capture, every cycle:
  - pending_next = (pending & ~clr_mask) | spike_req.
  - clr_mask is the one-hot of the winner loaded this cycle.
  - A new spike on the same bit that is being cleared wins: the bit stays set. That is a new event.
  - A spike on a bit that is already pending merges and is lost (one event per neuron).
- Load condition: load = (!out_valid || out_ready) && |pending.
- Arbitration:
  - Search pending only, never same-cycle spike_req.
  - Start at rr_ptr and scan upward modulo N. The first set bit is the winner w.
  - Wrap-around: with rr_ptr = N-1 and only bit 0 set, w = 0.
- On load:
  - out_addr <= w, out_valid <= 1.
  - grant_ack <= one-hot(w) for exactly one cycle.
  - rr_ptr <= (w == N-1) ? 0 : w+1.
- No load with out_valid && out_ready: out_valid <= 0. grant_ack is 0 in every cycle without a load.
- Stall: while out_valid && !out_ready, out_addr and out_valid hold stable. Pending continues to accumulate.
- Throughput and latency:
  - Back-to-back: one event per cycle while out_ready is held high.
  - Latency: spike at edge k sets pending at k; out_valid at k+1 (minimum 1 cycle spike-to-valid).
- Output FSM, two states:
  - EMPTY (out_valid = 0) goes to FULL when |pending.
  - FULL stays in FULL when out_ready && |pending (reload).
  - FULL goes to EMPTY when out_ready && !|pending.
  - FULL stays in FULL when !out_ready.
- Flush:
  - Clears pending and does not touch the output register or rr_ptr.
  - spike_req in the flush cycle is also dropped.
  - Flush has priority over load: no load in the flush cycle.
- busy = |pending || out_valid, combinational from registers.

Optional Feature:
- Macro: SPIKE_ARB_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 16 bits.
  - Increments once per cycle in which spike_req & pending & ~clr_mask != 0, i.e. at least one spike merged.
  - Saturates at 16'hFFFF. Cleared by reset and by flush.
- Undefined: no port and no logic. Merging behaviour is unchanged.

Decomposition:
- Shared package spike_arb_pkg holds:
  - typedef arb_state_t enum {EMPTY, FULL}.
  - Constant DROP_CNT_W = 16.
- One sub-module, rr_priority_pick:
  - Combinational.
  - Inputs: pending[N], rr_ptr[M].
  - Outputs: found, winner index [M], winner one-hot [N].
  - Implemented as a rotate, priority-encode, un-rotate.

Test Plan (N=8):
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-stream with out_valid=1.
  - Required: out_valid, grant_ack and busy drop immediately; after release, no event until a new spike.
- Single spike:
  - Stimulus: spike_req=8'h10 for 1 cycle, out_ready=1.
  - Required: next cycle out_valid=1, out_addr=4, grant_ack=8'h10; the cycle after, out_valid=0 and busy=0.
- Round-robin fairness:
  - Stimulus: spike_req=8'hFF for 1 cycle, out_ready=1.
  - Required: out_addr sequence 0..7 on consecutive cycles; rr_ptr ends at 0.
  - Then spike_req=8'h81 with rr_ptr=5: addresses 7, then 0.
- Backpressure:
  - Stimulus: spike_req=8'h0C, out_ready=0 for 5 cycles.
  - Required: out_addr=2 held stable with out_valid=1; after out_ready=1, address 3 appears the next cycle.
- Merge/re-arm:
  - Stimulus: pending bit 3 set and stalled, second spike on bit 3.
  - Required: only one address-3 event; drop_cnt=1 when the macro is defined.
  - Stimulus: spike on bit 3 in its own load cycle.
  - Required: a second address-3 event follows.
- Flush:
  - Stimulus: spike_req=8'hF0, then flush=1 while out_addr=4 is waiting.
  - Required: address 4 is still delivered; addresses 5-7 never appear; busy=0 afterwards.

Source files
------------

// File: rtl/spike_arb_pkg.sv
// Shared types and constants for the spike event arbiter.
package spike_arb_pkg;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate pending so rr_ptr lands at bit 0,
// take the lowest set bit, then map that offset back to a neuron index.
module rr_priority_pick #(
  parameter  int N = 8,
  localparam int M = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [M-1:0] rr_ptr,
  output logic         found,
  output logic [M-1:0] winner,
  output logic [N-1:0] winner_oh
);

  logic [N-1:0] rot;
  logic [M-1:0] off;
  logic [M:0]   sum;

  // Shifting the doubled vector handles a non-power-of-two N without a modulo.
  assign rot = N'({pending, pending} >> rr_ptr);

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = M'(i);
  end

  assign found     = |pending;
  assign sum       = {1'b0, off} + {1'b0, rr_ptr};
  assign winner    = (sum >= (M+1)'(N)) ? M'(sum - (M+1)'(N)) : sum[M-1:0];
  assign winner_oh = found ? (N'(1) << winner) : '0;

endmodule

// File: rtl/spike_event_arbiter.sv
// Round-robin serialiser of single-cycle neuron spikes into an AER address stream.
// Optional merged-spike counter output enabled by SPIKE_ARB_DROP_CNT_EN.
module spike_event_arbiter
  import spike_arb_pkg::*;
#(
  parameter  int N = 8,
  localparam int M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] spike_req,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_addr,
  output logic [N-1:0] grant_ack,
  output logic         busy
`ifdef SPIKE_ARB_DROP_CNT_EN
  ,output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [N-1:0] pending;
  logic [N-1:0] clr_mask;
  logic [N-1:0] win_oh;
  logic [M-1:0] win_idx;
  logic [M-1:0] rr_ptr;
  logic         found;
  logic         load;
  arb_state_t   state, state_nxt;

  rr_priority_pick #(.N(N)) u_pick (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .found     (found),
    .winner    (win_idx),
    .winner_oh (win_oh)
  );

  assign out_valid = (state == FULL);
  // Flush wins over load so the cleared pending set is never sampled.
  assign load      = !flush && (!out_valid || out_ready) && found;
  assign clr_mask  = load ? win_oh : '0;
  assign busy      = (|pending) || out_valid;

  // A fresh spike on the bit being granted re-arms it as a new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= (pending & ~clr_mask) | spike_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr  <= '0;
      grant_ack <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_addr  <= win_idx;
      grant_ack <= win_oh;
      rr_ptr    <= (win_idx == M'(N - 1)) ? '0 : win_idx + M'(1);
    end else begin
      grant_ack <= '0;
    end
  end

`ifdef SPIKE_ARB_DROP_CNT_EN
  logic [N-1:0] merged;

  assign merged = spike_req & pending & ~clr_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (flush)
      drop_cnt <= '0;
    else if ((|merged) && (drop_cnt != '1))
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end
`endif

endmodule
